// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-frame servo pulse generator with a double-buffered width.
// The requested width is latched into a shadow register only in the first cycle
// of each frame, so mid-frame updates never produce runt or stretched pulses.
// Optional feature: define SERVO_PWM_CLAMP_EN to clamp the latched width into
// [MIN_PULSE, MAX_PULSE] and report clamping on oClampHit. Without it the width
// saturates at PERIOD and oClampHit is tied low.
module servo_pwm_gen #(
   parameter int PERIOD    = 1000000,
   parameter int MIN_PULSE = 25000,
   parameter int MAX_PULSE = 125000,
   parameter int CNT_W     = 20
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEnable,
   input  logic [31:0] iPulseWidth,
   output logic        oPwm,
   output logic        oFrameStart,
   output logic [31:0] oPulseWidth,
   output logic        oClampHit
);

   localparam logic [31:0]      PERIOD_W  = 32'(PERIOD);
   localparam logic [31:0]      MIN_W     = 32'(MIN_PULSE);
   localparam logic [31:0]      MAX_W     = 32'(MAX_PULSE);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);

   // Configuration sanity checks, evaluated at elaboration time only.
   if ((64'd1 << CNT_W) < 64'(PERIOD)) begin : g_bad_cnt_w
      $error("servo_pwm_gen: CNT_W too narrow for PERIOD");
   end
   if (MIN_PULSE > MAX_PULSE) begin : g_bad_range
      $error("servo_pwm_gen: MIN_PULSE exceeds MAX_PULSE");
   end

   // HIGH/LOW mirror the line level produced for the previous frame cycle;
   // the frame-start cycle is any non-IDLE cycle with cnt == 0.
   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      shadow_q, shadow_d;
   logic             pwm_q, pwm_d;
   logic             fs_q, fs_d;
   logic             clamp_q, clamp_d;

   logic [31:0]      eff_width;
   logic             eff_clamped;
   logic [31:0]      cnt_ext;
   logic             frame_start;
   logic             last_cycle;
   logic             pwm_next;

   // Effective width of the live request: clamp or saturate, never wrap.
   always_comb begin
      eff_width   = iPulseWidth;
      eff_clamped = 1'b0;
`ifdef SERVO_PWM_CLAMP_EN
      if (iPulseWidth < MIN_W) begin
         eff_width   = MIN_W;
         eff_clamped = 1'b1;
      end else if (iPulseWidth > MAX_W) begin
         eff_width   = MAX_W;
         eff_clamped = 1'b1;
      end
`else
      if (iPulseWidth > PERIOD_W) begin
         eff_width = PERIOD_W;
      end
`endif
   end

   // Frame position decode and the line level for the current frame cycle.
   always_comb begin
      cnt_ext     = 32'(cnt_q);
      frame_start = (state_q != S_IDLE) && (cnt_q == '0);
      last_cycle  = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
      if (frame_start) begin
         pwm_next = (cnt_ext < eff_width);
      end else begin
         // Pulse is monotonic: once low, it stays low until the next frame.
         pwm_next = (state_q == S_HIGH) && (cnt_ext < shadow_q);
      end
   end

   // State and frame counter registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: disable is honoured only at the end of a frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (iEnable) begin
               state_d = S_LOW;
            end
         end
         S_HIGH, S_LOW: begin
            if (last_cycle) begin
               cnt_d   = '0;
               state_d = iEnable ? (pwm_next ? S_HIGH : S_LOW) : S_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = pwm_next ? S_HIGH : S_LOW;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic: strobe, shadow load and clamp flag at frame start.
   always_comb begin
      pwm_d    = pwm_next;
      fs_d     = frame_start;
      shadow_d = shadow_q;
      clamp_d  = clamp_q;
      if (frame_start) begin
         shadow_d = eff_width;
         clamp_d  = eff_clamped;
      end
   end

   // Registered outputs; reset forces the line low even mid-pulse.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         pwm_q    <= 1'b0;
         fs_q     <= 1'b0;
         shadow_q <= '0;
         clamp_q  <= 1'b0;
      end else begin
         pwm_q    <= pwm_d;
         fs_q     <= fs_d;
         shadow_q <= shadow_d;
         clamp_q  <= clamp_d;
      end
   end

   assign oPwm        = pwm_q;
   assign oFrameStart = fs_q;
   assign oPulseWidth = shadow_q;
   assign oClampHit   = clamp_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen with PERIOD=100, MIN_PULSE=5, MAX_PULSE=25.
// The driver pushes the expected per-frame result whenever it sets the width a
// frame will latch; a monitor measures each frame and pops/compares.
module tb_servo_pwm_gen;

   localparam int P    = 100;
   localparam int MINP = 5;
   localparam int MAXP = 25;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] pw;
   logic        o_pwm;
   logic        o_fs;
   logic [31:0] o_pw;
   logic        o_clamp;

   typedef struct {
      int unsigned hi;
      logic [31:0] width;
      logic        clamp;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned fs_count = 0;

   servo_pwm_gen #(
      .PERIOD    (P),
      .MIN_PULSE (MINP),
      .MAX_PULSE (MAXP),
      .CNT_W     (7)
   ) dut (
      .iClk        (clk),
      .iRst        (rst),
      .iEnable     (en),
      .iPulseWidth (pw),
      .oPwm        (o_pwm),
      .oFrameStart (o_fs),
      .oPulseWidth (o_pw),
      .oClampHit   (o_clamp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] eff_of(input logic [31:0] x);
`ifdef SERVO_PWM_CLAMP_EN
      if (x < 32'(MINP)) return 32'(MINP);
      if (x > 32'(MAXP)) return 32'(MAXP);
      return x;
`else
      return (x > 32'(P)) ? 32'(P) : x;
`endif
   endfunction

   function automatic logic clamp_of(input logic [31:0] x);
`ifdef SERVO_PWM_CLAMP_EN
      return (x < 32'(MINP)) || (x > 32'(MAXP));
`else
      return (x == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   task automatic push_exp(input logic [31:0] w);
      exp_t e;
      e.width = eff_of(w);
      e.hi    = (e.width > 32'(P)) ? P : int'(e.width);
      e.clamp = clamp_of(w);
      sb.push_back(e);
   endtask

   // Drive point: 1 time unit after the active edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fs();
      for (int i = 0; i < 3 * P; i++) begin
         @(negedge clk);
         if (o_fs) return;
      end
      check("fs_timeout", {31'b0, o_fs}, 32'd1);
   endtask

   task automatic mid_change(input logic [31:0] w);
      tick(50);
      pw = w;
      push_exp(w);
      wait_fs();
   endtask

   // Frame monitor: measures high time, latched width and clamp flag per frame.
   initial begin : monitor
      logic        in_frame;
      int unsigned len;
      int unsigned hi;
      logic [31:0] cap_w;
      logic        cap_c;
      exp_t        e;
      in_frame = 1'b0;
      len = 0;
      hi = 0;
      cap_w = '0;
      cap_c = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_frame = 1'b0;
         end else begin
            if (o_fs) begin
               fs_count++;
               if (in_frame) check("frame_len", len, P);
               in_frame = 1'b1;
               len   = 1;
               hi    = o_pwm ? 1 : 0;
               cap_w = o_pw;
               cap_c = o_clamp;
            end else if (in_frame) begin
               len++;
               if (o_pwm) hi++;
            end else if (o_pwm) begin
               check("pwm_outside_frame", {31'b0, o_pwm}, 32'd0);
            end
            if (in_frame && len == P) begin
               in_frame = 1'b0;
               if (sb.size() == 0) begin
                  check("sb_empty", sb.size(), 32'd1);
               end else begin
                  e = sb.pop_front();
                  check("high_cycles", hi, e.hi);
                  check("shadow_width", cap_w, e.width);
                  check("clamp_hit", {31'b0, cap_c}, {31'b0, e.clamp});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int unsigned lat;
      int unsigned fs0;
      logic [31:0] wa;
      logic [31:0] wb;
      rst = 1'b1;
      en  = 1'b0;
      pw  = '0;
      tick(3);
      check("rst_pwm", {31'b0, o_pwm}, 32'd0);
      check("rst_fs", {31'b0, o_fs}, 32'd0);
      check("rst_width", o_pw, 32'd0);
      check("rst_clamp", {31'b0, o_clamp}, 32'd0);
      rst = 1'b0;
      tick(2);

      // Enable latency and steady frames, then a mid-frame width change.
      pw = 32'd10;
      push_exp(32'd10);
      en = 1'b1;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (o_fs) break;
      end
      check("en_latency", lat, 32'd2);
      check("pwm_first_cycle", {31'b0, o_pwm}, 32'd1);
      mid_change(32'd10);
      mid_change(32'd20);
      mid_change(32'd10);

      // Disable at cycle 3 of the pulse: full pulse, frame completes, then idle.
      tick(3);
      en = 1'b0;
      fs0 = fs_count;
      tick(250);
      check("no_fs_after_disable", fs_count, fs0);
      check("pwm_idle_level", {31'b0, o_pwm}, 32'd0);
      check("sb_drained_1", sb.size(), 32'd0);

      // Boundary widths.
`ifdef SERVO_PWM_CLAMP_EN
      wa = 32'd2;
      wb = 32'hFFFF_FFFF;
`else
      wa = 32'd0;
      wb = 32'd500;
`endif
      pw = wa;
      push_exp(wa);
      en = 1'b1;
      wait_fs();
      mid_change(wb);
      tick(10);
      en = 1'b0;
      tick(150);
      check("sb_drained_2", sb.size(), 32'd0);
      check("pwm_idle_after_sat", {31'b0, o_pwm}, 32'd0);

      // Reset mid-pulse, then restart with a full first frame.
      pw = 32'd10;
      push_exp(32'd10);
      en = 1'b1;
      wait_fs();
      tick(4);
      check("pwm_before_rst", {31'b0, o_pwm}, 32'd1);
      rst = 1'b1;
      sb.delete();
      tick(1);
      check("rst2_pwm", {31'b0, o_pwm}, 32'd0);
      check("rst2_fs", {31'b0, o_fs}, 32'd0);
      check("rst2_width", o_pw, 32'd0);
      check("rst2_clamp", {31'b0, o_clamp}, 32'd0);
      tick(2);
      push_exp(32'd10);
      rst = 1'b0;
      wait_fs();
      tick(20);
      en = 1'b0;
      tick(150);
      check("sb_drained_3", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
